// File: rtl/conv3x3_pkg.sv
// rtl/conv3x3_pkg.sv - shared tap constants and arithmetic helpers for conv3x3_multich
package conv3x3_pkg;

  localparam int WIN  = 3;
  localparam int TAPS = WIN * WIN;

  // Tap k = 3*i + j; i = 0 is the oldest row, j = 0 the oldest column.
  function automatic int tap_idx(input int i, input int j);
    return WIN * i + j;
  endfunction

  function automatic int sum_width(input int dw, input int cw, input int ch);
    return dw + cw + 4 + $clog2(ch);
  endfunction

  function automatic logic [63:0] sat_shift(input logic [63:0] v, input int sh, input int ow);
    logic [63:0] s;
    logic [63:0] lim;
    s   = v >> sh;
    lim = (64'd1 << ow) - 64'd1;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/line_buf_2tap.sv
// rtl/line_buf_2tap.sv - write-gated shift memory giving samples one and two lines old
module line_buf_2tap #(
  parameter int DW    = 8,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout1,
  output logic [DW-1:0] dout2
);

  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem1[0] <= din;
      mem2[0] <= mem1[DEPTH-1];
      for (int k = 1; k < DEPTH; k++) begin
        mem1[k] <= mem1[k-1];
        mem2[k] <= mem2[k-1];
      end
    end
  end

  // Read before the concurrent write: the sample DEPTH and 2*DEPTH writes back.
  assign dout1 = mem1[DEPTH-1];
  assign dout2 = mem2[DEPTH-1];

endmodule

// File: rtl/conv3x3_multich.sv
// rtl/conv3x3_multich.sv - streaming multi-channel 3x3 weighted-sum filter, 4-stage pipeline
// CONV3X3_REPLICATE_EN: replicate nearest in-frame pixel at edges instead of zero padding
module conv3x3_multich
  import conv3x3_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CH    = 3,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = 4,
  parameter int OW    = 8,
  parameter int SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [CH*DW-1:0]      in_data,
  input  logic [CH*TAPS*CW-1:0] coef,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic [OW-1:0]         out_data
);

  localparam int PW  = DW + CW;
  localparam int CSW = DW + CW + 4;
  localparam int TW  = sum_width(DW, CW, CH);
  localparam int RW  = $clog2(IMG_H);
  localparam int CLW = $clog2(IMG_W);

  logic [RW-1:0]  row_cnt, cur_row;
  logic [CLW-1:0] col_cnt, cur_col;

  always_comb begin
    cur_row = in_sof ? '0 : row_cnt;
    cur_col = in_sof ? '0 : col_cnt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (in_valid) begin
      if (cur_col == CLW'(IMG_W - 1)) begin
        col_cnt <= '0;
        row_cnt <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_cnt <= cur_col + CLW'(1);
        row_cnt <= cur_row;
      end
    end
  end

  logic [DW-1:0] lb1 [CH];
  logic [DW-1:0] lb2 [CH];

  for (genvar g = 0; g < CH; g++) begin : g_lb
    line_buf_2tap #(.DW(DW), .DEPTH(IMG_W)) u_lb (
      .clk   (clk),
      .we    (in_valid),
      .din   (in_data[g*DW +: DW]),
      .dout1 (lb1[g]),
      .dout2 (lb2[g])
    );
  end

  // raw holds the unsubstituted window: two history columns plus the arriving one.
  logic [DW-1:0] hist [CH][WIN][2];
  logic [DW-1:0] raw  [CH][WIN][WIN];
  logic [DW-1:0] tap  [CH][TAPS];

  always_comb begin
    raw = '{default: '0};
    for (int ch = 0; ch < CH; ch++) begin
      for (int i = 0; i < WIN; i++) begin
        raw[ch][i][0] = hist[ch][i][0];
        raw[ch][i][1] = hist[ch][i][1];
      end
      raw[ch][0][2] = lb2[ch];
      raw[ch][1][2] = lb1[ch];
      raw[ch][2][2] = in_data[ch*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int ch = 0; ch < CH; ch++) begin
        for (int i = 0; i < WIN; i++) begin
          hist[ch][i][0] <= hist[ch][i][1];
          hist[ch][i][1] <= raw[ch][i][2];
        end
      end
    end
  end

`ifdef CONV3X3_REPLICATE_EN
  // Out-of-frame row/col index clamps to the window slot holding row/col 0.
  function automatic logic [1:0] src_idx(input int k, input int pos);
    return (pos + k < 2) ? 2'(2 - pos) : 2'(k);
  endfunction
`endif

  always_comb begin
    tap = '{default: '0};
    for (int ch = 0; ch < CH; ch++) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN; j++) begin
`ifdef CONV3X3_REPLICATE_EN
          tap[ch][tap_idx(i, j)] = raw[ch][src_idx(i, int'(cur_row))][src_idx(j, int'(cur_col))];
`else
          tap[ch][tap_idx(i, j)] = (int'(cur_row) + i < 2 || int'(cur_col) + j < 2) ? '0 : raw[ch][i][j];
`endif
        end
      end
    end
  end

  logic [CH*TAPS*CW-1:0] coef_reg, s1_coef;
  logic [DW-1:0]         s1_tap [CH][TAPS];
  logic                  s1_valid, s1_sof, s1_eol;
  logic [PW-1:0]         s2_prod [CH][TAPS];
  logic                  s2_valid, s2_sof, s2_eol;
  logic [CSW-1:0]        ch_sum [CH];
  logic [CSW-1:0]        s3_sum [CH];
  logic                  s3_valid, s3_sof, s3_eol;
  logic [TW-1:0]         total;
  logic [OW-1:0]         sat_val;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coef_reg <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      if (in_valid && in_sof) coef_reg <= coef;
    end
  end

  // Coefficients travel with S1 so a new frame never retunes older pixels.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_tap  <= tap;
      s1_coef <= in_sof ? coef : coef_reg;
      s1_sof  <= (cur_row == '0) && (cur_col == '0);
      s1_eol  <= (cur_col == CLW'(IMG_W - 1));
    end
  end

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < CH; ch++) begin
      for (int k = 0; k < TAPS; k++) begin
        s2_prod[ch][k] <= PW'(s1_tap[ch][k]) * PW'(s1_coef[(ch*TAPS+k)*CW +: CW]);
      end
    end
    s2_sof <= s1_sof;
    s2_eol <= s1_eol;
  end

  always_comb begin
    ch_sum = '{default: '0};
    for (int ch = 0; ch < CH; ch++) begin
      for (int k = 0; k < TAPS; k++) begin
        ch_sum[ch] = ch_sum[ch] + CSW'(s2_prod[ch][k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    s3_sum <= ch_sum;
    s3_sof <= s2_sof;
    s3_eol <= s2_eol;
  end

  always_comb begin
    total = '0;
    for (int ch = 0; ch < CH; ch++) begin
      total = total + TW'(s3_sum[ch]);
    end
    sat_val = OW'(sat_shift(64'(total), SHIFT, OW));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        out_data <= sat_val;
        out_sof  <= s3_sof;
        out_eol  <= s3_eol;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_multich.sv
// tb/tb_conv3x3_multich.sv - randomized self-checking bench for conv3x3_multich against a frame model
module tb_conv3x3_multich;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_sof = 1'b0;
  logic [CH*DW-1:0]     in_data = '0;
  logic [CH*9*CW-1:0]   coef = '0;
  logic                 ov0, os0, oe0, ov1, os1, oe1;
  logic [7:0]           od0, od1;

  always #5 clk = ~clk;

  conv3x3_multich #(.DW(DW), .CH(CH), .IMG_W(W), .IMG_H(H), .CW(CW), .OW(8), .SHIFT(0)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data), .coef(coef),
    .out_valid(ov0), .out_sof(os0), .out_eol(oe0), .out_data(od0));

  conv3x3_multich #(.DW(DW), .CH(CH), .IMG_W(W), .IMG_H(H), .CW(CW), .OW(8), .SHIFT(12)) u_dut_sh (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data), .coef(coef),
    .out_valid(ov1), .out_sof(os1), .out_eol(oe1), .out_data(od1));

  typedef struct {
    int due;
    int d0;
    int d1;
    bit sof;
    bit eol;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0, cyc = 0;
  int   img [CH][H][W];
  int   cf_drv [CH][9];
  int   cf_frm [CH][9];
  int   px [CH];
  int   mr = 0, mc = 0;
  int   last_d0 = 0, last_d1 = 0;
  bit   last_sof = 0, last_eol = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int pix(input int ch, input int r, input int c);
`ifdef CONV3X3_REPLICATE_EN
    if (r < 0) r = 0;
    if (c < 0) c = 0;
`else
    if (r < 0 || c < 0) return 0;
`endif
    return img[ch][r][c];
  endfunction

  task automatic model_pixel(input bit sof);
    exp_t   e;
    longint total = 0;
    if (sof) begin
      mr = 0;
      mc = 0;
      cf_frm = cf_drv;
    end
    for (int ch = 0; ch < CH; ch++) img[ch][mr][mc] = px[ch];
    for (int ch = 0; ch < CH; ch++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          total += longint'(cf_frm[ch][3*i+j]) * pix(ch, mr - 2 + i, mc - 2 + j);
    e.due = cyc + 4;
    e.d0  = int'((total > 255) ? 255 : total);
    e.d1  = int'(((total >> 12) > 255) ? 255 : (total >> 12));
    e.sof = (mr == 0 && mc == 0);
    e.eol = (mc == W - 1);
    q.push_back(e);
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("out_valid", ov0, 1);
      chk("out_valid_sh", ov1, 1);
      chk("out_data", od0, e.d0);
      chk("out_data_sh", od1, e.d1);
      chk("out_sof", os0, e.sof);
      chk("out_eol", oe0, e.eol);
      last_d0 = e.d0;
      last_d1 = e.d1;
      last_sof = e.sof;
      last_eol = e.eol;
    end else begin
      chk("idle_valid", ov0, 0);
      chk("idle_valid_sh", ov1, 0);
      chk("hold_data", od0, last_d0);
      chk("hold_data_sh", od1, last_d1);
      chk("hold_sof", os0, last_sof);
      chk("hold_eol", oe0, last_eol);
    end
  endtask

  task automatic tick(input bit v, input bit sof);
    @(negedge clk);
    cyc++;
    check_outputs();
    in_valid = v;
    in_sof   = v & sof;
    for (int ch = 0; ch < CH; ch++) in_data[ch*DW +: DW] = px[ch][7:0];
    for (int ch = 0; ch < CH; ch++)
      for (int k = 0; k < 9; k++) coef[(ch*9+k)*CW +: CW] = cf_drv[ch][k][3:0];
    if (v) model_pixel(sof);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rstn = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    q.delete();
    mr = 0;
    mc = 0;
    foreach (cf_frm[c, k]) cf_frm[c][k] = 0;
    #1;
    chk("rst_valid", ov0, 0);
    chk("rst_data", od0, 0);
    chk("rst_sof", os0, 0);
    chk("rst_eol", oe0, 0);
    chk("rst_data_sh", od1, 0);
    @(negedge clk);
    cyc++;
    rstn = 1'b1;
    last_d0 = 0;
    last_d1 = 0;
    last_sof = 0;
    last_eol = 0;
  endtask

  task automatic set_coef_all(input int v);
    foreach (cf_drv[c, k]) cf_drv[c][k] = v;
  endtask

  task automatic set_coef_rand();
    foreach (cf_drv[c, k]) cf_drv[c][k] = int'($urandom_range(0, 15));
  endtask

  task automatic set_px_all(input int v);
    foreach (px[c]) px[c] = v;
  endtask

  task automatic set_px_rand();
    foreach (px[c]) px[c] = int'($urandom_range(0, 255));
  endtask

  initial begin
    do_reset();

    // Unity coefficients on a flat image: edge sums depend on padding mode.
    set_coef_all(1);
    set_px_all(1);
    for (int p = 0; p < W * H; p++) tick(1, p == 0);

    // Saturation, then the shifted instance on a unity-coefficient bright frame.
    set_coef_all(15);
    set_px_all(255);
    for (int p = 0; p < W * H; p++) tick(1, p == 0);
    set_coef_all(1);
    for (int p = 0; p < W * H; p++) tick(1, p == 0);

    // Ramp frame continuous, then the same ramp with a 1-0-0 valid pattern.
    set_coef_rand();
    for (int p = 0; p < W * H; p++) begin
      foreach (px[c]) px[c] = (p * 7 + c * 17) & 255;
      tick(1, p == 0);
    end
    for (int p = 0; p < W * H; p++) begin
      foreach (px[c]) px[c] = (p * 7 + c * 17) & 255;
      tick(1, p == 0);
      tick(0, 0);
      tick(0, 0);
    end

    // Random frame with random gaps, restarted mid-frame at (2,5) with tap 8 only.
    set_coef_rand();
    for (int p = 0; p < 2 * W + 5; p++) begin
      set_px_rand();
      tick(1, p == 0);
      if ($urandom_range(0, 3) == 0) tick(0, 0);
    end
    set_coef_all(0);
    foreach (cf_drv[c]) cf_drv[c][8] = 1;
    set_px_rand();
    tick(1, 1);
    for (int p = 0; p < 40; p++) begin
      set_px_rand();
      tick(1, 0);
      if ($urandom_range(0, 3) == 0) tick(0, 0);
    end

    // Reset mid-line with pixels in flight, then sof-less pixels, then a fresh frame.
    set_coef_rand();
    for (int p = 0; p < 3; p++) begin
      set_px_rand();
      tick(1, 0);
    end
    do_reset();
    for (int p = 0; p < 10; p++) begin
      set_px_rand();
      tick(1, 0);
    end
    set_coef_rand();
    for (int p = 0; p < W * H + 5; p++) begin
      set_px_rand();
      tick(1, p == 0);
    end

    repeat (8) tick(0, 0);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
